zone_accum: RTL

ZONE_ACCUM -- requirements
Module: zone_accum

---
 rtl/led_mean_pkg.sv | 25 ++
 rtl/sat_acc21.sv | 34 +++
 rtl/zone_accum.sv | 127 ++++++++++++
 3 files changed

// File: rtl/led_mean_pkg.sv
// Shared types and constants for the zone accumulator.
// Holds zone count, widths, saturation ceiling, FSM state type.
package led_mean_pkg;

  localparam int ZONES = 8;
  localparam int PIX_W = 8;
  localparam int SUM_W = 21;
  localparam logic [SUM_W-1:0] SUM_MAX = 21'h1FFFFF;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // SUM_MAX is all-ones, so carry-out means "exceeded"
  function automatic logic [SUM_W-1:0] sat_add(
    input logic [SUM_W-1:0] a,
    input logic [PIX_W-1:0] p
  );
    logic [SUM_W:0] s;
    s = {1'b0, a} + {{(SUM_W + 1 - PIX_W){1'b0}}, p};
    return s[SUM_W] ? SUM_MAX : s[SUM_W-1:0];
  endfunction

endpackage

// File: rtl/sat_acc21.sv
// One saturating 21-bit accumulate/clear lane.
// Ports: clk, rst_n (sync, low), i_clr, i_en, i_pix, o_next (value after this edge).
module sat_acc21
  import led_mean_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [PIX_W-1:0] i_pix,
  output logic [SUM_W-1:0] o_next
);

  logic [SUM_W-1:0] r_sum;

  // clr with en loads the pixel: start-of-frame beat
  always_comb begin
    o_next = r_sum;
    if (i_clr) begin
      o_next = i_en ? {{(SUM_W - PIX_W){1'b0}}, i_pix} : '0;
    end else if (i_en) begin
      o_next = sat_add(r_sum, i_pix);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else begin
      r_sum <= o_next;
    end
  end

endmodule

// File: rtl/zone_accum.sv
// Per-zone R/G/B frame sums over 8 column zones, latched at end of frame.
// Ports: clk, rst_n, pix_valid_i, sof_i, eof_i, pix_r/g/b_i, SumR/G/B, start_o.
module zone_accum
  import led_mean_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int ZONE_W   = 240
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid_i,
  input  logic             sof_i,
  input  logic             eof_i,
  input  logic [PIX_W-1:0] pix_r_i,
  input  logic [PIX_W-1:0] pix_g_i,
  input  logic [PIX_W-1:0] pix_b_i,
  output logic [SUM_W-1:0] SumR [ZONES],
  output logic [SUM_W-1:0] SumG [ZONES],
  output logic [SUM_W-1:0] SumB [ZONES],
  output logic             start_o
);

  // line width is authoritative if the two parameters disagree
  localparam int ZW = (H_ACTIVE == ZONES * ZONE_W) ? ZONE_W
                                                    : H_ACTIVE / ZONES;
  localparam int XW = (ZW > 1) ? $clog2(ZW) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(ZW - 1);

  state_t       r_state;
  logic [XW-1:0] r_x;
  logic [2:0]   r_zone;

  logic          w_sof;
  logic          w_eof;
  logic          w_beat;
  logic [2:0]    w_zsel;
  logic [XW-1:0] w_xsel;
  logic [2:0]    w_next_zone;
  logic [XW-1:0] w_next_x;
  logic [ZONES-1:0] w_en;

  logic [SUM_W-1:0] w_nr [ZONES];
  logic [SUM_W-1:0] w_ng [ZONES];
  logic [SUM_W-1:0] w_nb [ZONES];

  assign w_sof  = pix_valid_i & sof_i;
  assign w_eof  = pix_valid_i & eof_i;
  assign w_beat = pix_valid_i & (sof_i | (r_state == ACCUM));

  // a sof beat always lands at zone 0, column 0
  assign w_zsel = sof_i ? 3'd0 : r_zone;
  assign w_xsel = sof_i ? '0 : r_x;

  // 3-bit zone index wraps 7 -> 0 at end of line
  always_comb begin
    w_next_x    = w_xsel + XW'(1);
    w_next_zone = w_zsel;
    if (w_xsel == X_LAST) begin
      w_next_x    = '0;
      w_next_zone = w_zsel + 3'd1;
    end
  end

  assign w_en = w_beat ? (ZONES'(1) << w_zsel) : '0;

  for (genvar z = 0; z < ZONES; z++) begin : g_zone
    sat_acc21 u_r (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_sof),
      .i_en   (w_en[z]),
      .i_pix  (pix_r_i),
      .o_next (w_nr[z])
    );
    sat_acc21 u_g (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_sof),
      .i_en   (w_en[z]),
      .i_pix  (pix_g_i),
      .o_next (w_ng[z])
    );
    sat_acc21 u_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_sof),
      .i_en   (w_en[z]),
      .i_pix  (pix_b_i),
      .o_next (w_nb[z])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_zone  <= '0;
      start_o <= 1'b0;
      for (int z = 0; z < ZONES; z++) begin
        SumR[z] <= '0;
        SumG[z] <= '0;
        SumB[z] <= '0;
      end
    end else begin
      start_o <= 1'b0;
      if (w_beat) begin
        if (w_eof) begin
          // latch the post-edge values so the eof pixel is included
          for (int z = 0; z < ZONES; z++) begin
            SumR[z] <= w_nr[z];
            SumG[z] <= w_ng[z];
            SumB[z] <= w_nb[z];
          end
          start_o <= 1'b1;
          r_state <= IDLE;
          r_x     <= '0;
          r_zone  <= '0;
        end else begin
          r_state <= ACCUM;
          r_x     <= w_next_x;
          r_zone  <= w_next_zone;
        end
      end
    end
  end

endmodule
